// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result capture, HI/LO registers, 2-entry result FIFO, sticky flags, retired counter
module alu_writeback #(
    parameter int WIDTH = 2,
    parameter int SEL_W = 5,
    parameter int CNT_W = 8,
    parameter logic [SEL_W-1:0] OP_MULT = SEL_W'(24),
    parameter logic [SEL_W-1:0] OP_MFHI = SEL_W'(16),
    parameter logic [SEL_W-1:0] OP_MFLO = SEL_W'(18)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [WIDTH-1:0] in_out,
    input  logic [WIDTH-1:0] in_hi,
    input  logic [WIDTH-1:0] in_lo,
    input  logic             in_error,
    input  logic             in_zero,
    input  logic             in_carry,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [SEL_W-1:0] out_sel,
    output logic [3:0]       out_flags,
    input  logic             clr_sticky,
    output logic [2:0]       sticky_flags,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q,
    output logic [CNT_W-1:0] retired
);

    logic [WIDTH-1:0] res_mem [2];
    logic [SEL_W-1:0] sel_mem [2];
    logic [3:0]       flg_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] push_result;
    logic [3:0]       push_flags;
    logic [2:0]       push_sticky;

    assign in_ready = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    // Head is forced to zero when empty so a drained FIFO looks like reset.
    assign out_result = out_valid ? res_mem[rd_ptr] : '0;
    assign out_sel    = out_valid ? sel_mem[rd_ptr] : '0;
    assign out_flags  = out_valid ? flg_mem[rd_ptr] : '0;

    // MFHI/MFLO substitute the architectural register and rebuild the flags.
    always_comb begin
        push_result = in_out;
        push_flags  = {in_error, in_zero, in_carry, in_overflow};
        if (in_sel == OP_MFHI || in_sel == OP_MFLO) begin
            push_result = (in_sel == OP_MFHI) ? hi_q : lo_q;
            push_flags  = {in_error, (push_result == '0), 1'b0, 1'b0};
        end
        push_sticky = {push_flags[3], push_flags[1], push_flags[0]};
    end

    // FIFO storage and pointers; simultaneous push/pop keeps count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                res_mem[i] <= '0;
                sel_mem[i] <= '0;
                flg_mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                res_mem[wr_ptr] <= push_result;
                sel_mem[wr_ptr] <= in_sel;
                flg_mem[wr_ptr] <= push_flags;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (accept && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !accept) begin
                count <= count - 2'd1;
            end
        end
    end

    // HI/LO follow only successful multiplies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (accept && in_sel == OP_MULT && !in_error) begin
            hi_q <= in_hi;
            lo_q <= in_lo;
        end
    end

    // Sticky flags: a flag arriving with the clear still sets its bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
        end else if (clr_sticky) begin
            sticky_flags <= accept ? push_sticky : 3'b000;
        end else if (accept) begin
            sticky_flags <= sticky_flags | push_sticky;
        end
    end

    // Retired counter wraps naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (pop) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - self-checking bench for alu_writeback
module tb_alu_writeback;

    localparam int WIDTH = 2;
    localparam int SEL_W = 5;
    localparam int CNT_W = 8;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_MULT = 5'd24;
    localparam logic [4:0] OP_MFHI = 5'd16;
    localparam logic [4:0] OP_MFLO = 5'd18;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic [WIDTH-1:0] in_out;
    logic [WIDTH-1:0] in_hi;
    logic [WIDTH-1:0] in_lo;
    logic             in_error;
    logic             in_zero;
    logic             in_carry;
    logic             in_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [SEL_W-1:0] out_sel;
    logic [3:0]       out_flags;
    logic             clr_sticky;
    logic [2:0]       sticky_flags;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] retired;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [SEL_W-1:0] sel;
        logic [3:0]       flags;
    } entry_t;

    entry_t           sb[$];
    logic [WIDTH-1:0] model_hi;
    logic [WIDTH-1:0] model_lo;
    logic [CNT_W-1:0] exp_retired;
    int               checks = 0;
    int               errors = 0;

    alu_writeback #(
        .WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W),
        .OP_MULT(OP_MULT), .OP_MFHI(OP_MFHI), .OP_MFLO(OP_MFLO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_out(in_out), .in_hi(in_hi), .in_lo(in_lo),
        .in_error(in_error), .in_zero(in_zero), .in_carry(in_carry), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_sel(out_sel), .out_flags(out_flags),
        .clr_sticky(clr_sticky), .sticky_flags(sticky_flags),
        .hi_q(hi_q), .lo_q(lo_q), .retired(retired)
    );

    always #5 clk = ~clk;

    // Scoreboard: every pop the DUT is about to perform is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got result=%0d sel=%0d flags=%b, expected nothing", out_result, out_sel, out_flags);
            end else begin
                entry_t e;
                e = sb.pop_front();
                if ({out_result, out_sel, out_flags} !== e) begin
                    errors++;
                    $display("FAIL pop_data: got result=%0d sel=%0d flags=%b, expected result=%0d sel=%0d flags=%b",
                             out_result, out_sel, out_flags, e.result, e.sel, e.flags);
                end
            end
            exp_retired = exp_retired + 1'b1;
        end
    end

    task automatic drive(input logic [4:0] s, input logic [1:0] o, input logic [1:0] h, input logic [1:0] l,
                         input logic e, input logic z, input logic c, input logic v);
        entry_t exp;
        bit     accepted;
        accepted = 0;
        in_sel = s; in_out = o; in_hi = h; in_lo = l;
        in_error = e; in_zero = z; in_carry = c; in_overflow = v;
        in_valid = 1'b1;
        for (int k = 0; k < 64 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp.sel = s;
                if (s == OP_MFHI || s == OP_MFLO) begin
                    exp.result = (s == OP_MFHI) ? model_hi : model_lo;
                    exp.flags  = {e, (exp.result == 2'd0), 1'b0, 1'b0};
                end else begin
                    exp.result = o;
                    exp.flags  = {e, z, c, v};
                end
                sb.push_back(exp);
                if (s == OP_MULT && !e) begin
                    model_hi = h;
                    model_lo = l;
                end
                accepted = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected acceptance of sel=%0d", s);
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries still expected, expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_sel = '0; in_out = '0; in_hi = '0; in_lo = '0;
        in_error = 0; in_zero = 0; in_carry = 0; in_overflow = 0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        sb.delete();
        model_hi = '0; model_lo = '0; exp_retired = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out_result, out_sel, out_flags} !== {1'b0, 1'b1, 2'd0, 5'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b ready=%b res=%0d sel=%0d flags=%b, expected 0 1 0 0 0000",
                     out_valid, in_ready, out_result, out_sel, out_flags);
        end
        checks++;
        if ({hi_q, lo_q, sticky_flags, retired} !== '0) begin
            errors++;
            $display("FAIL reset_state: got hi=%0d lo=%0d sticky=%b retired=%0d, expected all 0", hi_q, lo_q, sticky_flags, retired);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_add();
        out_ready = 1'b1;
        drive(OP_ADD, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 2'd3) begin
            errors++;
            $display("FAIL add_head: got valid=%b result=%0d, expected 1 3", out_valid, out_result);
        end
        @(negedge clk);
        checks++;
        if (retired !== 8'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_retire: got retired=%0d valid=%b, expected 1 0", retired, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mult_hilo();
        out_ready = 1'b1;
        drive(OP_MULT, 2'b00, 2'b10, 2'b01, 0, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (hi_q !== 2'd2 || lo_q !== 2'd1) begin
            errors++;
            $display("FAIL mult_hilo: got hi=%0d lo=%0d, expected 2 1", hi_q, lo_q);
        end
        @(posedge clk); #1;
        drive(OP_MFHI, 2'b00, 2'b00, 2'b00, 0, 1, 1, 1);
        drive(OP_MFLO, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0);
        drive(OP_MULT, 2'b00, 2'b11, 2'b11, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (hi_q !== 2'd2 || lo_q !== 2'd1) begin
            errors++;
            $display("FAIL mult_error_hold: got hi=%0d lo=%0d, expected 2 1", hi_q, lo_q);
        end
        @(posedge clk); #1;
        drive(OP_MULT, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0);
        drive(OP_MFLO, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
        drain();
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("FAIL mult_retired: got %0d, expected %0d", retired, exp_retired);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] base;
        base = exp_retired;
        out_ready = 1'b0;
        drive(OP_ADD, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0);
        drive(OP_ADD, 2'd2, 2'd0, 2'd0, 0, 0, 1, 0);
        fork
            drive(OP_ADD, 2'd3, 2'd0, 2'd0, 0, 0, 0, 1);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || out_result !== 2'd1 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_hold: got ready=%b valid=%b result=%0d, expected 0 1 1", in_ready, out_valid, out_result);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (retired !== base + 8'd3) begin
            errors++;
            $display("FAIL bp_retired: got %0d, expected %0d", retired, base + 8'd3);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(5'd2, 2'd0, 2'd0, 2'd0, 0, 1, 0, 0);
        out_ready = 1'b1;
        fork
            for (int i = 1; i <= 10; i++) drive(5'(i + 2), 2'(i), 2'd0, 2'd0, 0, 0, 1'(i), 0);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_count: got valid=%b ready=%b at step %0d, expected 1 1", out_valid, in_ready, k);
                end
            end
        join
        drain();
    endtask

    task automatic test_sticky();
        out_ready = 1'b1;
        drive(OP_ADD, 2'd1, 2'd0, 2'd0, 1, 0, 1, 0);
        clr_sticky = 1'b1;
        drive(OP_ADD, 2'd2, 2'd0, 2'd0, 0, 0, 0, 1);
        clr_sticky = 1'b0;
        @(negedge clk);
        checks++;
        if (sticky_flags !== 3'b001) begin
            errors++;
            $display("FAIL sticky_set_wins: got %b, expected 001", sticky_flags);
        end
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        checks++;
        if (sticky_flags !== 3'b000) begin
            errors++;
            $display("FAIL sticky_clear: got %b, expected 000", sticky_flags);
        end
        @(posedge clk); #1;
        drive(OP_MFHI, 2'd0, 2'd0, 2'd0, 1, 0, 1, 1);
        @(negedge clk);
        checks++;
        if (sticky_flags !== 3'b100) begin
            errors++;
            $display("FAIL sticky_mfhi: got %b, expected 100", sticky_flags);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(OP_MULT, 2'd0, 2'd2, 2'd1, 0, 0, 0, 0);
        drive(OP_ADD, 2'd3, 2'd0, 2'd0, 0, 0, 0, 0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || hi_q !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset: got ready=%b valid=%b hi=%0d, expected 0 1 2", in_ready, out_valid, hi_q);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || hi_q !== 2'd0 || lo_q !== 2'd0 || in_ready !== 1'b1 || retired !== 8'd0 || out_result !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b hi=%0d lo=%0d ready=%b retired=%0d res=%0d, expected 0 0 0 1 0 0",
                     out_valid, hi_q, lo_q, in_ready, retired, out_result);
        end
        sb.delete();
        model_hi = '0; model_lo = '0; exp_retired = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_retired_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 255; i++) drive(5'(i % 8), 2'(i), 2'd0, 2'd0, 0, 0, 0, 0);
        drain();
        checks++;
        if (retired !== 8'd255) begin
            errors++;
            $display("FAIL retired_255: got %0d, expected 255", retired);
        end
        drive(OP_ADD, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0);
        drain();
        checks++;
        if (retired !== 8'd0) begin
            errors++;
            $display("FAIL retired_wrap: got %0d, expected 0", retired);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_mult_hilo();
        test_backpressure();
        test_back_to_back();
        test_sticky();
        test_reset_mid();
        test_retired_wrap();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
